// File: rtl/cache_def.sv
// Shared cache/memory interface types, plus the state encoding of the
// cache-to-memory arbiter.
package cache_def;

    typedef logic [127:0] cache_data_type;

    typedef struct packed {
        logic [31:0]    addr;
        cache_data_type data;
        logic           rw;
        logic           valid;
    } mem_req_type;

    typedef struct packed {
        cache_data_type data;
        logic           ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_type;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Two-port arbiter that gives two cache controllers access to one shared memory.
// Optional macro CACHE_ARB_ROUND_ROBIN_EN: a tie goes to the port not last served.
// Without it, port 0 wins every tie.
module cache_mem_arbiter
    import cache_def::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  mem_req_type        req0,
    output mem_data_type       rsp0,
    input  mem_req_type        req1,
    output mem_data_type       rsp1,
    output mem_req_type        mem_req,
    input  mem_data_type       mem_rsp,
    output logic [1:0]         grant,
    output logic [CNT_W-1:0]   cnt0,
    output logic [CNT_W-1:0]   cnt1
);

    arb_state_type state_r;
    arb_state_type state_next_s;
    logic          done0_s;
    logic          done1_s;

    assign done0_s = (state_r == OWN0) && mem_rsp.ready;
    assign done1_s = (state_r == OWN1) && mem_rsp.ready;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic last_r;

    // Last-served pointer; starts at 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (done0_s) begin
            last_r <= 1'b0;
        end else if (done1_s) begin
            last_r <= 1'b1;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state. An owner keeps the memory until it signals ready.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req0.valid && req1.valid) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    if (last_r) begin
                        state_next_s = OWN0;
                    end else begin
                        state_next_s = OWN1;
                    end
`else
                    state_next_s = OWN0;
`endif
                end else if (req0.valid) begin
                    state_next_s = OWN0;
                end else if (req1.valid) begin
                    state_next_s = OWN1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            OWN0: begin
                if (mem_rsp.ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OWN0;
                end
            end
            OWN1: begin
                if (mem_rsp.ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OWN1;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output routing. Valid is forced high so that a withdrawn request still completes.
    always_comb begin
        mem_req = '0;
        rsp0    = '0;
        rsp1    = '0;
        grant   = 2'b00;
        case (state_r)
            IDLE: begin
                grant = 2'b00;
            end
            OWN0: begin
                mem_req       = req0;
                mem_req.valid = 1'b1;
                rsp0          = mem_rsp;
                grant         = 2'b01;
            end
            OWN1: begin
                mem_req       = req1;
                mem_req.valid = 1'b1;
                rsp1          = mem_rsp;
                grant         = 2'b10;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

    // Completed-transaction counters. They wrap without saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (done0_s) begin
                cnt0 <= cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt0 <= cnt0;
            end
            if (done1_s) begin
                cnt1 <= cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt1 <= cnt1;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter. The stimulus pushes the expected
// responses into a queue, and a negedge monitor pops and checks them.
module tb_cache_mem_arbiter;
    import cache_def::*;

    typedef struct {
        int             port;
        cache_data_type data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    mem_req_type  req0, req1, mem_req, mem_req_w2;
    mem_data_type rsp0, rsp1, mem_rsp, rsp0_w2, rsp1_w2;
    logic [1:0]   grant, grant_w2;
    logic [15:0]  cnt0, cnt1;
    logic [1:0]   cnt0_w2, cnt1_w2;

    exp_t sb[$];
    exp_t mon_e;
    int   mon_port;
    int   total = 0;
    int   bad = 0;
    int   m_cnt0 = 0;
    int   m_cnt1 = 0;

    cache_mem_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .rsp0(rsp0), .req1(req1), .rsp1(rsp1),
        .mem_req(mem_req), .mem_rsp(mem_rsp), .grant(grant), .cnt0(cnt0), .cnt1(cnt1)
    );

    cache_mem_arbiter #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .rsp0(rsp0_w2), .req1(req1), .rsp1(rsp1_w2),
        .mem_req(mem_req_w2), .mem_rsp(mem_rsp), .grant(grant_w2), .cnt0(cnt0_w2), .cnt1(cnt1_w2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cache_data_type mem_data_of(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0DE_0000 | {16'h0000, a[15:0]}};
    endfunction

    // Monitor: each response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && (rsp0.ready || rsp1.ready)) begin
            chk("rsp_both_ready", {255'd0, rsp0.ready & rsp1.ready}, 256'd0);
            mon_port = rsp1.ready ? 1 : 0;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got response on port %0d expected none", mon_port);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_port", mon_port, mon_e.port);
                chk("rsp_data", mon_port == 1 ? rsp1.data : rsp0.data, mon_e.data);
                chk("rsp_other_zero", mon_port == 1 ? rsp0 : rsp1, 256'd0);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = '0;
        req1 = '0;
        mem_rsp = '0;
        m_cnt0 = 0;
        m_cnt1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Wait for the grant, hold memory busy for lat cycles, then complete one transfer.
    task automatic serve(input int lat, input int exp_port, input bit drop, output int waited);
        mem_req_type    exp_req;
        cache_data_type d;
        logic [1:0]     eg;
        waited = 0;
        while (!mem_req.valid && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("mem_valid", {255'd0, mem_req.valid}, 256'd1);
        if (!mem_req.valid) return;
        eg = (exp_port == 1) ? 2'b10 : 2'b01;
        exp_req = (exp_port == 1) ? req1 : req0;
        exp_req.valid = 1'b1;
        chk("grant", grant, eg);
        chk("mem_req_fields", mem_req, exp_req);
        for (int i = 0; i < lat; i++) begin
            @(posedge clk);
            #1;
            chk("grant_hold", grant, eg);
        end
        d = mem_data_of(exp_req.addr);
        mem_rsp.data = d;
        mem_rsp.ready = 1'b1;
        sb.push_back('{exp_port, d});
        @(posedge clk);
        #1;
        mem_rsp = '0;
        if (drop && exp_port == 1) req1.valid = 1'b0;
        if (drop && exp_port == 0) req0.valid = 1'b0;
        if (exp_port == 1) m_cnt1++;
        else m_cnt0++;
        chk("grant_idle_after", grant, 2'b00);
        chk("mem_req_idle_after", mem_req, 256'd0);
        chk("cnt0", cnt0, m_cnt0 % 65536);
        chk("cnt1", cnt1, m_cnt1 % 65536);
        chk("cnt0_w2", cnt0_w2, m_cnt0 % 4);
    endtask

    initial begin
        int w;
        int exp_owner;
        req0 = '0;
        req1 = '0;
        mem_rsp = '0;
        #12;
        chk("rst_grant", grant, 2'b00);
        chk("rst_mem_req", mem_req, 256'd0);
        chk("rst_rsp0", rsp0, 256'd0);
        chk("rst_rsp1", rsp1, 256'd0);
        chk("rst_cnt0", cnt0, 256'd0);
        chk("rst_cnt1", cnt1, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request on port 0.
        req0 = '{addr: 32'h0000_1000, data: 128'h0, rw: 1'b0, valid: 1'b1};
        serve(3, 0, 1'b1, w);
        chk("arb_latency", w, 1);
        chk("single_cnt0", cnt0, 16'd1);

        // A memory ready pulse while idle must not be routed or counted.
        mem_rsp = '{data: 128'hDEAD_BEEF, ready: 1'b1};
        @(negedge clk);
        chk("idle_rdy_rsp0", rsp0, 256'd0);
        chk("idle_rdy_rsp1", rsp1, 256'd0);
        chk("idle_rdy_grant", grant, 2'b00);
        @(posedge clk);
        #1;
        mem_rsp = '0;
        chk("idle_rdy_cnt0", cnt0, 16'd1);
        chk("idle_rdy_cnt1", cnt1, 16'd0);

        // Both ports request at once and hold their requests through four transfers.
        do_reset();
        req0 = '{addr: 32'h0000_4000, data: 128'h11, rw: 1'b1, valid: 1'b1};
        req1 = '{addr: 32'h0000_8000, data: 128'h22, rw: 1'b0, valid: 1'b1};
        for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            exp_owner = k % 2;
`else
            exp_owner = 0;
`endif
            serve(2, exp_owner, 1'b0, w);
        end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        chk("rr_cnt0", cnt0, 16'd2);
        chk("rr_cnt1", cnt1, 16'd2);
`else
        chk("fp_cnt0", cnt0, 16'd4);
        chk("fp_cnt1", cnt1, 16'd0);
`endif
        req0.valid = 1'b0;
        req1.valid = 1'b0;
        @(posedge clk);
        #1;

        // Port 1 withdraws after one cycle; its transfer must still complete.
        req1 = '{addr: 32'h0000_2468, data: 128'h33, rw: 1'b0, valid: 1'b1};
        @(posedge clk);
        #1;
        req1.valid = 1'b0;
        serve(5, 1, 1'b1, w);
        repeat (3) @(posedge clk);
        #1;
        chk("withdraw_sb_empty", sb.size(), 0);

        // Reset in the middle of a port-0 transfer.
        req0 = '{addr: 32'h0000_1111, data: 128'h44, rw: 1'b0, valid: 1'b1};
        @(posedge clk);
        #1;
        chk("pre_rst_valid", {255'd0, mem_req.valid}, 256'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {255'd0, mem_req.valid}, 256'd0);
        chk("midrst_grant", grant, 2'b00);
        chk("midrst_cnt0", cnt0, 16'd0);
        req0 = '0;
        req1 = '{addr: 32'h0000_2000, data: 128'h55, rw: 1'b1, valid: 1'b1};
        m_cnt0 = 0;
        m_cnt1 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        serve(1, 1, 1'b1, w);
        chk("post_rst_latency", w, 1);

        // Counter wrap on the 2-bit instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req0 = '{addr: 32'h0000_3000 + 32'(i * 16), data: 128'h0, rw: 1'b0, valid: 1'b1};
            serve(0, 0, 1'b1, w);
        end
        chk("wrap_cnt0_w2", cnt0_w2, 2'd1);
        chk("wrap_cnt0", cnt0, 16'd5);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, width of each per-port completed-transaction counter.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0  input  mem_req_type  memory request from cache controller 0.
REQ-006 rsp0  output  mem_data_type  memory response to cache controller 0.
REQ-007 req1  input  mem_req_type  memory request from cache controller 1.
REQ-008 rsp1  output  mem_data_type  memory response to cache controller 1.
REQ-009 mem_req  output  mem_req_type  request to the shared memory.
REQ-010 mem_rsp  input  mem_data_type  response from the shared memory.
REQ-011 grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-012 cnt0, cnt1  output  CNT_W  completed transactions per port.

Function
REQ-013 FSM states SHALL be IDLE, OWN0 and OWN1.
REQ-014 In IDLE with exactly one reqN.valid=1, the next state SHALL be OWNN.
REQ-015 In IDLE with both valid, the winner SHALL be chosen per REQ-029/REQ-030.
REQ-016 In IDLE with no valid request, the FSM SHALL stay in IDLE.
REQ-017 Arbitration latency: mem_req.valid SHALL first assert the cycle after the winning request is seen in IDLE.
REQ-018 In IDLE, mem_req SHALL be all-zero and grant SHALL be 2'b00.
REQ-019 In OWNN, mem_req SHALL combinationally equal reqN with valid forced to 1, and grant[N] SHALL be 1.
REQ-020 In OWNN, rspN.data SHALL equal mem_rsp.data and rspN.ready SHALL equal mem_rsp.ready.
REQ-021 The non-owner rsp SHALL be all-zero; in IDLE, rsp0 and rsp1 SHALL be all-zero.
REQ-022 In OWNN, mem_rsp.ready=1 SHALL return the FSM to IDLE, increment cntN and update the last-served pointer to N.
REQ-023 The FSM SHALL hold OWNN until mem_rsp.ready, even if reqN.valid drops; the memory transaction is not abandoned.
REQ-024 mem_rsp.ready in IDLE SHALL be ignored: no routing, no counter change.
REQ-025 A new grant SHALL be possible no earlier than the cycle after completion, giving at least one idle cycle between transactions.
REQ-026 Counters SHALL wrap modulo 2^CNT_W without saturation or flag.
REQ-027 Requesters SHALL hold reqN stable while valid until rspN.ready; the arbiter SHALL NOT register request fields.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, grant=0, mem_req=0, rsp0=rsp1=0, cnt0=cnt1=0, last-served pointer=1; assertion mid-transaction SHALL drop mem_req.valid immediately, with no completion counted.

Configuration
REQ-029 With CACHE_ARB_ROUND_ROBIN_EN defined, a simultaneous request SHALL be granted to the port not last served; after reset, port 0 wins first.
REQ-030 Without CACHE_ARB_ROUND_ROBIN_EN, port 0 SHALL always win a simultaneous request, and the last-served pointer SHALL be absent or unused.

Structure
REQ-031 mem_req_type, mem_data_type and cache_data_type SHALL come from the shared cache_def package.
REQ-032 A new arb_state_type enum (IDLE, OWN0, OWN1) SHALL be added to cache_def.
REQ-033 The design SHALL be a single module with no sub-module; the grant-select logic is small enough to remain inline.

Verification
REQ-034 Single request: reset, req0={addr=0x0000_1000,rw=0,valid=1}, memory ready 3 cycles after mem_req.valid -> mem_req.addr=0x1000 from cycle 1; rsp0.ready=1 with memory data in one cycle; cnt0=1; rsp1 stays 0.
REQ-035 Simultaneous requests, round robin: req0 and req1 valid, each held until served, 4 transactions -> owners 0,1,0,1; cnt0=cnt1=2.
REQ-036 Simultaneous requests, fixed priority (macro undefined): req0 held valid continuously, req1 valid -> port 1 never granted while req0 valid; cnt1=0.
REQ-037 Requester withdraws: req1 valid one cycle then dropped, memory ready after 5 cycles -> grant=2'b10 held all 5 cycles; rsp1.ready pulses once; cnt1=1.
REQ-038 Reset mid-op: rst_n low during OWN0 -> mem_req.valid=0 and grant=0 in the same cycle; cnt0=0; after release, req1 alone is granted next.
REQ-039 Wrap: CNT_W=2, 5 port-0 transactions -> cnt0=1.
